// File: rtl/l1_mem_arbiter_if.sv
// Bus bundle between l1_mem_arbiter and its neighbours: both L1 caches and the MMU line port.
// master = arbiter view; slave = caches/MMU view.
interface l1_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              i_req_read;
   logic [ADDR_W-1:0] i_req_addr;
   logic              i_read_done;
   logic [LINE_W-1:0] i_read_data;

   logic              d_req_read;
   logic              d_req_write;
   logic [ADDR_W-1:0] d_req_addr;
   logic [LINE_W-1:0] d_write_data;
   logic              d_read_done;
   logic              d_write_done;
   logic [LINE_W-1:0] d_read_data;

   logic              arb_mmu_req_read;
   logic              arb_mmu_req_write;
   logic [ADDR_W-1:0] arb_mmu_req_addr;
   logic [LINE_W-1:0] arb_mmu_write_data;
   logic              mmu_arb_read_done;
   logic              mmu_arb_write_done;
   logic [LINE_W-1:0] mmu_arb_read_data;

   logic              arb_busy;
   logic [1:0]        arb_grant;

   modport master (
      input  i_req_read, i_req_addr,
      output i_read_done, i_read_data,
      input  d_req_read, d_req_write, d_req_addr, d_write_data,
      output d_read_done, d_write_done, d_read_data,
      output arb_mmu_req_read, arb_mmu_req_write, arb_mmu_req_addr, arb_mmu_write_data,
      input  mmu_arb_read_done, mmu_arb_write_done, mmu_arb_read_data,
      output arb_busy, arb_grant
   );

   modport slave (
      output i_req_read, i_req_addr,
      input  i_read_done, i_read_data,
      output d_req_read, d_req_write, d_req_addr, d_write_data,
      input  d_read_done, d_write_done, d_read_data,
      input  arb_mmu_req_read, arb_mmu_req_write, arb_mmu_req_addr, arb_mmu_write_data,
      output mmu_arb_read_done, mmu_arb_write_done, mmu_arb_read_data,
      input  arb_busy, arb_grant
   );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Arbitrates the single MMU line port between L1 I-cache (read) and L1 D-cache (read/write).
// Optional ARB_ROUND_ROBIN_EN: round-robin on I/D ties; otherwise D-cache wins ties.
module l1_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic             sys_clk,
   input  logic             rst,
   l1_mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;

   state_t            state_q, state_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [1:0]        grant_q, grant_d;
   logic              busy_q, busy_d;
   logic              i_done_q, i_done_d, d_rdone_q, d_rdone_d, d_wdone_q, d_wdone_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic              i_any, d_any, pick_d, mmu_done;

   assign i_any    = bus.i_req_read;
   assign d_any    = bus.d_req_read | bus.d_req_write;
   assign mmu_done = (rd_q & bus.mmu_arb_read_done) | (wr_q & bus.mmu_arb_write_done);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;
   assign pick_d = d_any & (~i_any | ~last_d_q);
`else
   assign pick_d = d_any;
`endif

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      grant_d   = grant_q;
      i_done_d  = 1'b0;
      d_rdone_d = 1'b0;
      d_wdone_d = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d  = last_d_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_any | d_any) begin
               state_d = BUSY;
               if (pick_d) begin
                  // write-back goes ahead of refill; the read stays pending on the held request
                  grant_d = 2'b10;
                  wr_d    = bus.d_req_write;
                  rd_d    = ~bus.d_req_write;
                  addr_d  = bus.d_req_addr;
                  wdata_d = bus.d_req_write ? bus.d_write_data : '0;
               end else begin
                  grant_d = 2'b01;
                  wr_d    = 1'b0;
                  rd_d    = 1'b1;
                  addr_d  = bus.i_req_addr;
                  wdata_d = '0;
               end
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = pick_d;
`endif
            end
         end
         BUSY: begin
            if (mmu_done) begin
               state_d = RESP;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               if (grant_q[1]) begin
                  d_rdone_d = rd_q;
                  d_wdone_d = wr_q;
                  if (rd_q) d_rdata_d = bus.mmu_arb_read_data;
               end else begin
                  i_done_d  = 1'b1;
                  i_rdata_d = bus.mmu_arb_read_data;
               end
            end
         end
         RESP:    state_d = HOLD;
         HOLD: begin
            state_d = IDLE;
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         i_done_q  <= 1'b0;
         d_rdone_q <= 1'b0;
         d_wdone_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         i_done_q  <= i_done_d;
         d_rdone_q <= d_rdone_d;
         d_wdone_q <= d_wdone_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q  <= last_d_d;
`endif
      end
   end

   assign bus.arb_mmu_req_read   = rd_q;
   assign bus.arb_mmu_req_write  = wr_q;
   assign bus.arb_mmu_req_addr   = addr_q;
   assign bus.arb_mmu_write_data = wdata_q;
   assign bus.arb_busy           = busy_q;
   assign bus.arb_grant          = grant_q;
   assign bus.i_read_done        = i_done_q;
   assign bus.i_read_data        = i_rdata_q;
   assign bus.d_read_done        = d_rdone_q;
   assign bus.d_write_done       = d_wdone_q;
   assign bus.d_read_data        = d_rdata_q;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: MMU model with 5-cycle latency and 4096-line RAM,
// directed scenarios plus a randomized run against a queue-free pending-set reference model.
module tb_l1_mem_arbiter;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic sys_clk = 1'b0;
   logic rst = 1'b1;
   int   chk = 0;
   int   pass = 0;
   logic [LINE_W-1:0] ram [4096];
   logic [LINE_W-1:0] ref_ram [4096];
   bit          stray_en = 1'b0;
   int unsigned mmu_cnt = 0;
   int unsigned n_idone = 0, n_drdone = 0, n_dwdone = 0;

   l1_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
   l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .sys_clk(sys_clk),
      .rst    (rst),
      .bus    (bus)
   );

   initial forever #5 sys_clk = ~sys_clk;

   function automatic logic [11:0] idx_of(input logic [ADDR_W-1:0] a);
      return a[16:5];
   endfunction

   // MMU model: done pulse on the 5th cycle a request is seen, RAM updated/read at that point
   initial begin
      bus.mmu_arb_read_done  = 1'b0;
      bus.mmu_arb_write_done = 1'b0;
      bus.mmu_arb_read_data  = '0;
      forever begin
         @(negedge sys_clk);
         bus.mmu_arb_read_done  = 1'b0;
         bus.mmu_arb_write_done = 1'b0;
         if (rst || !(bus.arb_mmu_req_read || bus.arb_mmu_req_write)) mmu_cnt = 0;
         else begin
            mmu_cnt++;
            if (stray_en && bus.arb_mmu_req_read && mmu_cnt == 2) bus.mmu_arb_write_done = 1'b1;
            if (mmu_cnt == 5) begin
               if (bus.arb_mmu_req_read) begin
                  bus.mmu_arb_read_data = ram[idx_of(bus.arb_mmu_req_addr)];
                  bus.mmu_arb_read_done = 1'b1;
               end else begin
                  ram[idx_of(bus.arb_mmu_req_addr)] = bus.arb_mmu_write_data;
                  bus.mmu_arb_write_done = 1'b1;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge sys_clk);
      if (bus.i_read_done === 1'b1) n_idone++;
      if (bus.d_read_done === 1'b1) n_drdone++;
      if (bus.d_write_done === 1'b1) n_dwdone++;
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.i_req_read   = 1'b0;
      bus.i_req_addr   = '0;
      bus.d_req_read   = 1'b0;
      bus.d_req_write  = 1'b0;
      bus.d_req_addr   = '0;
      bus.d_write_data = '0;
   endtask

   task automatic pulse_reset();
      clear_reqs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (bus.i_read_done === 1'b1 || bus.d_read_done === 1'b1 || bus.d_write_done === 1'b1) begin
            cycles = n;
            break;
         end
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40; n++) begin
         if (bus.arb_busy !== 1'b1) break;
         step();
      end
   endtask

   task automatic wait_busy();
      for (int n = 0; n < 40; n++) begin
         step();
         if (bus.arb_busy === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      clear_reqs();
      rst = 1'b1;
      repeat (3) step();
      chk++; if (bus.arb_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.arb_busy); else pass++;
      chk++; if (bus.arb_grant !== 2'b00) $display("FAIL reset_grant got %b want 00", bus.arb_grant); else pass++;
      chk++; if ({bus.arb_mmu_req_read, bus.arb_mmu_req_write} !== 2'b00)
         $display("FAIL reset_mmu_req got %b%b want 00", bus.arb_mmu_req_read, bus.arb_mmu_req_write); else pass++;
      chk++; if (bus.arb_mmu_req_addr !== '0) $display("FAIL reset_addr got %h want 0", bus.arb_mmu_req_addr); else pass++;
      chk++; if (bus.arb_mmu_write_data !== '0) $display("FAIL reset_wdata got %h want 0", bus.arb_mmu_write_data); else pass++;
      chk++; if ({bus.i_read_done, bus.d_read_done, bus.d_write_done} !== 3'b000)
         $display("FAIL reset_done got %b%b%b want 000", bus.i_read_done, bus.d_read_done, bus.d_write_done); else pass++;
      chk++; if (bus.i_read_data !== '0 || bus.d_read_data !== '0)
         $display("FAIL reset_rdata got i=%h d=%h want 0", bus.i_read_data, bus.d_read_data); else pass++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_i_read();
      int c;
      int unsigned d0 = n_drdone + n_dwdone;
      bus.i_req_addr = 32'h0000_E00C;
      bus.i_req_read = 1'b1;
      step();
      chk++; if ({bus.arb_mmu_req_read, bus.arb_mmu_req_write} !== 2'b10)
         $display("FAIL iread_req got %b%b want 10", bus.arb_mmu_req_read, bus.arb_mmu_req_write); else pass++;
      chk++; if (bus.arb_mmu_req_addr !== 32'h0000_E00C) $display("FAIL iread_addr got %h want 0000e00c", bus.arb_mmu_req_addr); else pass++;
      chk++; if (bus.arb_grant !== 2'b01 || bus.arb_busy !== 1'b1)
         $display("FAIL iread_grant got %b busy %b want 01 busy 1", bus.arb_grant, bus.arb_busy); else pass++;
      wait_done(c);
      chk++; if (c != 5) $display("FAIL iread_latency got %0d want 5", c); else pass++;
      chk++; if (bus.i_read_done !== 1'b1 || bus.i_read_data !== ref_ram[12'h700])
         $display("FAIL iread_data got done %b data %h want %h", bus.i_read_done, bus.i_read_data, ref_ram[12'h700]); else pass++;
      bus.i_req_read = 1'b0;
      step();
      chk++; if (bus.i_read_done !== 1'b0 || bus.i_read_data !== ref_ram[12'h700])
         $display("FAIL iread_pulse got done %b data %h want 0 and held data", bus.i_read_done, bus.i_read_data); else pass++;
      wait_idle();
      chk++; if (n_drdone + n_dwdone != d0) $display("FAIL iread_no_d got %0d want %0d", n_drdone + n_dwdone, d0); else pass++;
   endtask

   task automatic test_d_write();
      int c;
      logic [LINE_W-1:0] wd = {8{32'hBBB00CCC}};
      int unsigned i0 = n_idone, w0 = n_dwdone;
      bus.d_req_addr   = 32'h0000_600C;
      bus.d_write_data = wd;
      bus.d_req_write  = 1'b1;
      step();
      chk++; if ({bus.arb_mmu_req_read, bus.arb_mmu_req_write} !== 2'b01 || bus.arb_grant !== 2'b10)
         $display("FAIL dwrite_req got rw %b%b grant %b want 01 grant 10", bus.arb_mmu_req_read, bus.arb_mmu_req_write, bus.arb_grant); else pass++;
      chk++; if (bus.arb_mmu_write_data !== wd) $display("FAIL dwrite_wdata got %h want %h", bus.arb_mmu_write_data, wd); else pass++;
      wait_done(c);
      chk++; if (c != 5 || bus.d_write_done !== 1'b1) $display("FAIL dwrite_done got lat %0d done %b want 5 1", c, bus.d_write_done); else pass++;
      bus.d_req_write = 1'b0;
      ref_ram[12'h300] = wd;
      wait_idle();
      chk++; if (ram[12'h300] !== wd) $display("FAIL dwrite_ram got %h want %h", ram[12'h300], wd); else pass++;
      chk++; if (n_dwdone != w0 + 1 || n_idone != i0)
         $display("FAIL dwrite_pulses got w %0d i %0d want %0d %0d", n_dwdone, n_idone, w0 + 1, i0); else pass++;
   endtask

   task automatic test_back_to_back();
      int c;
      logic [1:0] g;
      pulse_reset();
      bus.i_req_addr = 32'h0001_2340;
      bus.i_req_read = 1'b1;
      bus.d_req_addr = 32'h0000_E00C;
      bus.d_req_read = 1'b1;
      step();
      chk++; if (bus.arb_grant !== 2'b10 || bus.arb_mmu_req_addr !== 32'h0000_E00C)
         $display("FAIL tie1_grant got %b addr %h want 10 0000e00c", bus.arb_grant, bus.arb_mmu_req_addr); else pass++;
      wait_done(c);
      chk++; if (bus.d_read_done !== 1'b1 || bus.d_read_data !== ref_ram[12'h700])
         $display("FAIL tie1_data got done %b data %h want %h", bus.d_read_done, bus.d_read_data, ref_ram[12'h700]); else pass++;
      bus.d_req_read = 1'b0;
      step();
      bus.d_req_addr = 32'h0000_600C;
      bus.d_req_read = 1'b1;
      step();
      chk++; if (bus.arb_busy !== 1'b0) $display("FAIL b2b_gap got busy %b want 0", bus.arb_busy); else pass++;
      g = RR ? 2'b01 : 2'b10;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) step();
         else begin
            wait_idle();
            wait_busy();
         end
         chk++; if (bus.arb_grant !== g) $display("FAIL tie2_grant_%0d got %b want %b", t, bus.arb_grant, g); else pass++;
         wait_done(c);
         if (g == 2'b01) begin
            chk++; if (bus.i_read_done !== 1'b1 || bus.i_read_data !== ref_ram[12'h91A])
               $display("FAIL tie2_i got done %b data %h want %h", bus.i_read_done, bus.i_read_data, ref_ram[12'h91A]); else pass++;
            bus.i_req_read = 1'b0;
         end else begin
            chk++; if (bus.d_read_done !== 1'b1 || bus.d_read_data !== ref_ram[12'h300])
               $display("FAIL tie2_d got done %b data %h want %h", bus.d_read_done, bus.d_read_data, ref_ram[12'h300]); else pass++;
            bus.d_req_read = 1'b0;
         end
         g = ~g;
      end
      wait_idle();
   endtask

   task automatic test_d_both();
      int c;
      logic [LINE_W-1:0] wd = {8{32'hBBB00CCC}};
      bus.d_req_addr   = 32'h0000_800C;
      bus.d_write_data = wd;
      bus.d_req_read   = 1'b1;
      bus.d_req_write  = 1'b1;
      step();
      chk++; if ({bus.arb_mmu_req_read, bus.arb_mmu_req_write} !== 2'b01)
         $display("FAIL both_first got rw %b%b want 01", bus.arb_mmu_req_read, bus.arb_mmu_req_write); else pass++;
      wait_done(c);
      chk++; if (bus.d_write_done !== 1'b1 || bus.d_read_done !== 1'b0)
         $display("FAIL both_wdone got w %b r %b want 1 0", bus.d_write_done, bus.d_read_done); else pass++;
      bus.d_req_write = 1'b0;
      ref_ram[12'h400] = wd;
      wait_idle();
      wait_busy();
      chk++; if ({bus.arb_mmu_req_read, bus.arb_mmu_req_write} !== 2'b10)
         $display("FAIL both_second got rw %b%b want 10", bus.arb_mmu_req_read, bus.arb_mmu_req_write); else pass++;
      wait_done(c);
      chk++; if (bus.d_read_done !== 1'b1 || bus.d_read_data !== wd)
         $display("FAIL both_readback got done %b data %h want %h", bus.d_read_done, bus.d_read_data, wd); else pass++;
      bus.d_req_read = 1'b0;
      wait_idle();
   endtask

   task automatic test_stray();
      int c;
      int unsigned w0 = n_dwdone;
      stray_en = 1'b1;
      bus.i_req_addr = 32'h0000_2464;
      bus.i_req_read = 1'b1;
      step();
      wait_done(c);
      chk++; if (c != 5 || bus.i_read_done !== 1'b1)
         $display("FAIL stray_latency got lat %0d done %b want 5 1", c, bus.i_read_done); else pass++;
      chk++; if (bus.i_read_data !== ref_ram[12'h123]) $display("FAIL stray_data got %h want %h", bus.i_read_data, ref_ram[12'h123]); else pass++;
      bus.i_req_read = 1'b0;
      stray_en = 1'b0;
      wait_idle();
      chk++; if (n_dwdone != w0) $display("FAIL stray_no_dwdone got %0d want %0d", n_dwdone, w0); else pass++;
   endtask

   task automatic test_reset_mid();
      int c;
      int unsigned p0;
      bus.i_req_addr = 32'h0000_E00C;
      bus.i_req_read = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      step();
      chk++; if (bus.arb_busy !== 1'b0 || {bus.arb_mmu_req_read, bus.arb_mmu_req_write} !== 2'b00 || bus.arb_grant !== 2'b00)
         $display("FAIL rstmid_state got busy %b rw %b%b grant %b want 0 00 00", bus.arb_busy,
                  bus.arb_mmu_req_read, bus.arb_mmu_req_write, bus.arb_grant); else pass++;
      p0 = n_idone + n_drdone + n_dwdone;
      rst = 1'b0;
      bus.i_req_read = 1'b0;
      repeat (8) step();
      chk++; if (n_idone + n_drdone + n_dwdone != p0) $display("FAIL rstmid_nopulse got %0d want %0d", n_idone + n_drdone + n_dwdone, p0); else pass++;
      bus.i_req_read = 1'b1;
      step();
      wait_done(c);
      chk++; if (c != 5 || bus.i_read_done !== 1'b1 || bus.i_read_data !== ref_ram[12'h700])
         $display("FAIL rstmid_fresh got lat %0d done %b data %h want 5 1 %h", c, bus.i_read_done, bus.i_read_data, ref_ram[12'h700]); else pass++;
      bus.i_req_read = 1'b0;
      wait_idle();
   endtask

   // Reference: pending set {I read, D read, D write}; D beats I (or alternate under round-robin), write beats read
   task automatic test_random();
      int c;
      bit last_d = 1'b0;
      pulse_reset();
      for (int it = 0; it < 25; it++) begin
         logic [2:0] p = 3'($urandom_range(1, 7));
         logic [ADDR_W-1:0] ia = $urandom, da = $urandom;
         logic [LINE_W-1:0] wd;
         for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom;
         bus.i_req_addr = ia; bus.d_req_addr = da; bus.d_write_data = wd;
         bus.i_req_read = p[0]; bus.d_req_read = p[1]; bus.d_req_write = p[2];
         for (int t = 0; t < 3 && p != 3'b000; t++) begin
            bit pd = (p[1] | p[2]) && (!p[0] || !RR || !last_d);
            bit ew = pd && p[2];
            logic [ADDR_W-1:0] ea = pd ? da : ia;
            last_d = pd;
            wait_idle();
            wait_busy();
            chk++; if (bus.arb_grant !== (pd ? 2'b10 : 2'b01) || bus.arb_mmu_req_addr !== ea || bus.arb_mmu_req_write !== ew
                       || bus.arb_mmu_req_read !== !ew || (ew && bus.arb_mmu_write_data !== wd))
               $display("FAIL rnd_grant it%0d got g %b a %h rw %b%b want g %b a %h w %b", it, bus.arb_grant,
                        bus.arb_mmu_req_addr, bus.arb_mmu_req_read, bus.arb_mmu_req_write, pd ? 2'b10 : 2'b01, ea, ew); else pass++;
            wait_done(c);
            chk++; if (c != 5 || {bus.i_read_done, bus.d_read_done, bus.d_write_done} !== {!pd, pd && !ew, ew})
               $display("FAIL rnd_done it%0d got lat %0d dones %b%b%b want 5 %b%b%b", it, c, bus.i_read_done, bus.d_read_done,
                        bus.d_write_done, !pd, pd && !ew, ew); else pass++;
            if (ew) begin
               ref_ram[idx_of(ea)] = wd;
               p[2] = 1'b0; bus.d_req_write = 1'b0;
            end else if (pd) begin
               chk++; if (bus.d_read_data !== ref_ram[idx_of(ea)])
                  $display("FAIL rnd_ddata it%0d got %h want %h", it, bus.d_read_data, ref_ram[idx_of(ea)]); else pass++;
               p[1] = 1'b0; bus.d_req_read = 1'b0;
            end else begin
               chk++; if (bus.i_read_data !== ref_ram[idx_of(ea)])
                  $display("FAIL rnd_idata it%0d got %h want %h", it, bus.i_read_data, ref_ram[idx_of(ea)]); else pass++;
               p[0] = 1'b0; bus.i_req_read = 1'b0;
            end
         end
         wait_idle();
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++)
         for (int w = 0; w < 8; w++) ram[i][w*32 +: 32] = $urandom;
      ref_ram = ram;
      test_reset();
      test_i_read();
      test_d_write();
      test_back_to_back();
      test_d_both();
      test_stray();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end
endmodule
